// File: rtl/apb_irq_ctrl_pkg.sv
// Shared register map, ID layout and priority helper for the APB interrupt controller.
// Optional source synchronizer is selected with APB_IRQ_CTRL_SYNC_EN (see irq_edge_detect).
package apb_irq_ctrl_pkg;

   localparam int MAX_IRQ_CNT  = 32;
   localparam int ID_VALID_BIT = 31;

   localparam logic [1:0] MASK_OFS = 2'd0;
   localparam logic [1:0] PEND_OFS = 2'd1;
   localparam logic [1:0] PSET_OFS = 2'd2;
   localparam logic [1:0] ID_OFS   = 2'd3;

   typedef enum logic [1:0] {
      REG_MASK = MASK_OFS,
      REG_PEND = PEND_OFS,
      REG_PSET = PSET_OFS,
      REG_ID   = ID_OFS
   } reg_sel_e;

   // Lowest set index wins; returns 0 for an empty vector.
   function automatic logic [4:0] lowest_set(input logic [MAX_IRQ_CNT-1:0] vec);
      lowest_set = '0;
      for (int i = MAX_IRQ_CNT - 1; i >= 0; i--) begin
         if (vec[i]) lowest_set = 5'(i);
      end
   endfunction

endpackage

// File: rtl/apb_irq_ctrl_irq_edge_detect.sv
// Per-source rising-edge detector; with APB_IRQ_CTRL_SYNC_EN defined each source
// first passes through a 2-flop synchronizer so it may originate in another clock domain.
module irq_edge_detect
   import apb_irq_ctrl_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] src,
   output logic [WIDTH-1:0] rise
);

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         logic level;
         logic hist_reg;

`ifdef APB_IRQ_CTRL_SYNC_EN
         logic sync1_reg;
         logic sync2_reg;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sync1_reg <= 1'b0;
               sync2_reg <= 1'b0;
            end else begin
               sync1_reg <= src[gi];
               sync2_reg <= sync1_reg;
            end
         end

         assign level = sync2_reg;
`else
         assign level = src[gi];
`endif

         // History resets low, so a source already high at reset release yields an edge.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) hist_reg <= 1'b0;
            else        hist_reg <= level;
         end

         assign rise[gi] = level & ~hist_reg;
      end
   endgenerate

endmodule

// File: rtl/apb_irq_ctrl.sv
// APB interrupt controller: edge-latched pending bits, mask, registered combined IRQ
// and lowest-index ID. Define APB_IRQ_CTRL_SYNC_EN to synchronize irq_i into HCLK.
module apb_irq_ctrl
   import apb_irq_ctrl_pkg::*;
#(
   parameter int APB_ADDR_WIDTH = 12,
   parameter int IRQ_CNT        = 4
) (
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic [APB_ADDR_WIDTH-1:0] PADDR,
   input  logic [31:0]               PWDATA,
   input  logic                      PWRITE,
   input  logic                      PSEL,
   input  logic                      PENABLE,
   output logic [31:0]               PRDATA,
   output logic                      PREADY,
   output logic                      PSLVERR,
   input  logic [IRQ_CNT-1:0]        irq_i,
   output logic                      irq_o,
   output logic [4:0]                irq_id_o
);

   logic [IRQ_CNT-1:0]     mask_reg;
   logic [IRQ_CNT-1:0]     pend_reg;
   logic [IRQ_CNT-1:0]     pend_next;
   logic [IRQ_CNT-1:0]     rise;
   logic [IRQ_CNT-1:0]     w1c;
   logic [IRQ_CNT-1:0]     swset;
   logic [IRQ_CNT-1:0]     active;
   logic [MAX_IRQ_CNT-1:0] active_wide;
   logic                   irq_valid;
   logic                   addr_ok;
   logic                   wr_en;
   reg_sel_e               reg_sel;
   logic                   unused_ok;

   irq_edge_detect #(
      .WIDTH (IRQ_CNT)
   ) u_edge (
      .clk   (HCLK),
      .rst_n (HRESETn),
      .src   (irq_i),
      .rise  (rise)
   );

   // Only the first 16 bytes of the window decode; anything above is an error.
   assign addr_ok = (PADDR[APB_ADDR_WIDTH-1:4] == '0);
   assign wr_en   = PSEL & PENABLE & PWRITE & addr_ok;
   assign reg_sel = reg_sel_e'(PADDR[3:2]);

   assign PREADY  = 1'b1;
   assign PSLVERR = PSEL & ~addr_ok;

   always_comb begin
      w1c   = '0;
      swset = '0;
      if (wr_en && reg_sel == REG_PEND) w1c   = PWDATA[IRQ_CNT-1:0];
      if (wr_en && reg_sel == REG_PSET) swset = PWDATA[IRQ_CNT-1:0];
   end

   // Set terms are OR'ed after the clear so a simultaneous edge always survives.
   assign pend_next = (pend_reg & ~w1c) | rise | swset;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         mask_reg <= '0;
         pend_reg <= '0;
         irq_o    <= 1'b0;
      end else begin
         pend_reg <= pend_next;
         if (wr_en && reg_sel == REG_MASK) mask_reg <= PWDATA[IRQ_CNT-1:0];
         irq_o    <= |active;
      end
   end

   assign active    = pend_reg & mask_reg;
   assign irq_valid = |active;

   always_comb begin
      active_wide              = '0;
      active_wide[IRQ_CNT-1:0] = active;
   end

   assign irq_id_o = lowest_set(active_wide);

   always_comb begin
      PRDATA = '0;
      if (PSEL && addr_ok) begin
         case (reg_sel)
            REG_MASK: PRDATA[IRQ_CNT-1:0] = mask_reg;
            REG_PEND: PRDATA[IRQ_CNT-1:0] = pend_reg;
            REG_PSET: PRDATA = '0;
            REG_ID: begin
               PRDATA[ID_VALID_BIT] = irq_valid;
               PRDATA[4:0]          = irq_id_o;
            end
            default: PRDATA = '0;
         endcase
      end
   end

   assign unused_ok = ^{PWDATA, PADDR[1:0]};

endmodule

// File: tb/tb_apb_irq_ctrl.sv
// Self-checking bench for apb_irq_ctrl: directed register-map scenarios followed by
// randomized APB traffic and source activity, all checked against a behavioural model.
module tb_apb_irq_ctrl;

   localparam int AW  = 12;
   localparam int N   = 4;
   localparam bit [31:0] ALL = (32'd1 << N) - 32'd1;
`ifdef APB_IRQ_CTRL_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic          HCLK = 1'b0;
   logic          HRESETn;
   logic [AW-1:0] PADDR;
   logic [31:0]   PWDATA;
   logic          PWRITE;
   logic          PSEL;
   logic          PENABLE;
   logic [31:0]   PRDATA;
   logic          PREADY;
   logic          PSLVERR;
   logic [N-1:0]  irq_i;
   logic          irq_o;
   logic [4:0]    irq_id_o;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model state
   bit [31:0] m_mask, m_pend, m_prev;
   bit [31:0] m_hist [3];
   bit        m_irq_o;

   apb_irq_ctrl #(.APB_ADDR_WIDTH(AW), .IRQ_CNT(N)) dut (
      .HCLK     (HCLK),
      .HRESETn  (HRESETn),
      .PADDR    (PADDR),
      .PWDATA   (PWDATA),
      .PWRITE   (PWRITE),
      .PSEL     (PSEL),
      .PENABLE  (PENABLE),
      .PRDATA   (PRDATA),
      .PREADY   (PREADY),
      .PSLVERR  (PSLVERR),
      .irq_i    (irq_i),
      .irq_o    (irq_o),
      .irq_id_o (irq_id_o)
   );

   always #5 HCLK = ~HCLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit [31:0] exp_id();
      bit [31:0] act = m_pend & m_mask;
      for (int i = 0; i < N; i++) if (act[i]) return i;
      return 0;
   endfunction

   function automatic bit [31:0] exp_read(input bit [AW-1:0] a);
      if ((a >> 4) != 0) return 0;
      case (a[3:2])
         2'd0: return m_mask;
         2'd1: return m_pend;
         2'd2: return 0;
         default: return (((m_pend & m_mask) != 0) ? 32'h8000_0000 : 32'h0) | exp_id();
      endcase
   endfunction

   task automatic model_reset();
      m_mask = 0; m_pend = 0; m_prev = 0; m_irq_o = 0;
      for (int i = 0; i < 3; i++) m_hist[i] = 0;
   endtask

   // One clock edge of the spec's rules, using input values seen at that edge.
   task automatic model_step();
      bit [31:0] eff, rises, w1c, sset;
      bit        nxt_irq;
      if (!HRESETn) begin
         model_reset();
         return;
      end
      nxt_irq   = (m_pend & m_mask) != 0;
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = 32'(irq_i);
      eff       = m_hist[LAT];
      rises     = eff & ~m_prev;
      m_prev    = eff;
      w1c = 0; sset = 0;
      if (PSEL && PENABLE && PWRITE && (PADDR >> 4) == 0) begin
         case (PADDR[3:2])
            2'd0: m_mask = PWDATA & ALL;
            2'd1: w1c    = PWDATA & ALL;
            2'd2: sset   = PWDATA & ALL;
            default: ;
         endcase
      end
      m_pend  = ((m_pend & ~w1c) | rises | sset) & ALL;
      m_irq_o = nxt_irq;
   endtask

   task automatic tick();
      @(posedge HCLK);
      model_step();
      #1;
   endtask

   task automatic apb_write(input bit [AW-1:0] a, input bit [31:0] d);
      PSEL = 1; PWRITE = 1; PENABLE = 0; PADDR = a; PWDATA = d;
      tick();
      PENABLE = 1;
      tick();
      PSEL = 0; PENABLE = 0; PWRITE = 0;
   endtask

   task automatic apb_read(input bit [AW-1:0] a, output bit [31:0] d, output bit err);
      PSEL = 1; PWRITE = 0; PENABLE = 0; PADDR = a;
      tick();
      PENABLE = 1;
      #1;
      d   = PRDATA;
      err = PSLVERR;
      tick();
      PSEL = 0; PENABLE = 0;
   endtask

   // Continuous comparison of every observable output against the model.
   initial begin
      forever begin
         @(negedge HCLK);
         chk("irq_o", 32'(irq_o), 32'(m_irq_o));
         chk("irq_id_o", 32'(irq_id_o), exp_id());
         chk("pready", 32'(PREADY), 32'd1);
         chk("pslverr", 32'(PSLVERR), 32'(PSEL && ((PADDR >> 4) != 0)));
         if (PSEL && !PWRITE) chk("prdata", PRDATA, exp_read(PADDR));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit [31:0] rd;
      bit        er;
      bit [AW-1:0] addrs [8] = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h804, 12'h005, 12'hFFC};

      HRESETn = 0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0; irq_i = '0;
      model_reset();
      repeat (3) tick();
      HRESETn = 1;
      tick();

      // Reset state
      apb_read(12'h000, rd, er); chk("rst_mask", rd, 32'h0);
      apb_read(12'h004, rd, er); chk("rst_pend", rd, 32'h0);
      apb_read(12'h008, rd, er); chk("rst_pset", rd, 32'h0);
      apb_read(12'h00C, rd, er); chk("rst_id", rd, 32'h0);
      chk("rst_irq_o", 32'(irq_o), 32'h0);
      chk("rst_pready", 32'(PREADY), 32'h1);

      // Masked-in pulse on source 1
      apb_write(12'h000, 32'hF);
      irq_i = 4'h2; tick(); irq_i = 4'h0;
      repeat (LAT) tick();
      tick();
      chk("pulse1_irq_o", 32'(irq_o), 32'h1);
      apb_read(12'h004, rd, er); chk("pulse1_pend", rd, 32'h2);
      apb_read(12'h00C, rd, er); chk("pulse1_id", rd, 32'h8000_0001);
      apb_write(12'h004, 32'h2);
      tick();
      chk("w1c_irq_o", 32'(irq_o), 32'h0);

      // Masked-out pulse on source 3, then unmask
      apb_write(12'h000, 32'h0);
      irq_i = 4'h8; tick(); irq_i = 4'h0;
      repeat (LAT + 1) tick();
      chk("masked_irq_o", 32'(irq_o), 32'h0);
      apb_read(12'h004, rd, er); chk("masked_pend", rd, 32'h8);
      apb_write(12'h000, 32'h8);
      tick();
      chk("unmask_irq_o", 32'(irq_o), 32'h1);
      apb_read(12'h00C, rd, er); chk("unmask_id", rd, 32'h8000_0003);
      apb_write(12'h004, 32'hF);

      // Edge and W1C on the same bit in the same cycle: set wins
      if (LAT > 0) begin
         irq_i = 4'h1;
         repeat (LAT - 1) tick();
      end
      PSEL = 1; PWRITE = 1; PENABLE = 0; PADDR = 12'h004; PWDATA = 32'h1;
      tick();
      PENABLE = 1; irq_i = 4'h1;
      tick();
      PSEL = 0; PENABLE = 0; PWRITE = 0;
      apb_read(12'h004, rd, er); chk("set_beats_clr", rd, 32'h1);

      // Level held high latches only once
      irq_i = 4'h5;
      repeat (LAT + 2) tick();
      apb_write(12'h004, 32'h4);
      repeat (6) tick();
      irq_i = 4'h0;
      apb_read(12'h004, rd, er); chk("held_level", rd, 32'h1);

      // Software set and priority
      apb_write(12'h004, 32'hF);
      apb_write(12'h000, 32'hF);
      apb_write(12'h008, 32'h5);
      apb_read(12'h004, rd, er); chk("pset_pend", rd, 32'h5);
      apb_read(12'h00C, rd, er); chk("pset_id", rd, 32'h8000_0000);
      apb_read(12'h008, rd, er); chk("pset_reads0", rd, 32'h0);
      apb_write(12'h004, 32'h1);
      apb_read(12'h00C, rd, er); chk("pset_id2", rd, 32'h8000_0002);

      // Out-of-window access
      apb_write(12'h010, 32'h0);
      apb_read(12'h010, rd, er);
      chk("bad_prdata", rd, 32'h0);
      chk("bad_pslverr", 32'(er), 32'h1);
      apb_read(12'h000, rd, er); chk("bad_mask_kept", rd, 32'hF);

      // Asynchronous reset mid-operation
      apb_write(12'h008, 32'hF);
      tick();
      chk("pre_rst_irq_o", 32'(irq_o), 32'h1);
      #1 HRESETn = 0;
      #1;
      model_reset();
      chk("async_rst_irq_o", 32'(irq_o), 32'h0);
      chk("async_rst_id", 32'(irq_id_o), 32'h0);
      repeat (2) tick();
      HRESETn = 1;
      tick();
      apb_read(12'h004, rd, er); chk("post_rst_pend", rd, 32'h0);

      // Randomized traffic
      for (int it = 0; it < 800; it++) begin
         if ($urandom_range(0, 2) == 0) irq_i = N'($urandom);
         case ($urandom_range(0, 3))
            0: apb_write(addrs[$urandom_range(0, 7)], $urandom);
            1: apb_read(addrs[$urandom_range(0, 7)], rd, er);
            default: tick();
         endcase
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/apb_irq_ctrl.md
Name: apb_irq_ctrl

Overview:
- APB slave interrupt controller that sits directly downstream of the timer block and consumes its irq_o vector (overflow and compare per timer).
- Detects rising edges per source, latches them into pending bits, applies a mask, and produces one combined interrupt line plus a priority-encoded ID for the core.
- Same APB bus, clock and reset as the timer block.

Parameters:
- APB_ADDR_WIDTH, 12, APB address width (4KB slave window).
- IRQ_CNT, 4, number of interrupt sources (legal 1..32); default matches 2 timers x 2 lines.

Ports:
- HCLK  input  1  system clock; all state on rising edge.
- HRESETn  input  1  asynchronous active-low reset.
- PADDR  input  APB_ADDR_WIDTH  APB address.
- PWDATA  input  32  APB write data.
- PWRITE  input  1  APB write strobe.
- PSEL  input  1  APB select.
- PENABLE  input  1  APB enable (access phase).
- PRDATA  output  32  APB read data.
- PREADY  output  1  APB ready; constant 1 (zero wait states).
- PSLVERR  output  1  APB error.
- irq_i  input  IRQ_CNT  interrupt sources, bit 2k = timer k overflow, bit 2k+1 = timer k compare.
- irq_o  output  1  combined interrupt to core, registered.
- irq_id_o  output  5  index of lowest-numbered masked-in pending source; 0 when none.

Behaviour:
- Clock and reset: single clock HCLK; reset HRESETn is asynchronous, active-low. Reset clears mask, pending, irq_q (edge-history) and irq_o; irq_id_o = 0, PRDATA = 0, PSLVERR = 0, PREADY = 1.
- Edge detect: edge[i] = irq_i[i] & ~irq_q[i]; irq_q <= irq_i every cycle. A source already high when reset is released counts as an edge on the first cycle.
- Access: a write takes effect on PSEL & PENABLE & PWRITE at the clock edge. Reads are combinational in the access phase and have no side effects.
- Register map (word offsets, PADDR[3:2]):
  - 0x0 MASK: RW, bits [IRQ_CNT-1:0]; 1 = enabled.
  - 0x4 PENDING: R; write-1-to-clear.
  - 0x8 PENDING_SET: W only (software trigger: written 1s set pending); reads 0.
  - 0xC ID: RO; bit31 = valid (any pending & mask), [4:0] = irq_id_o.
- Unused bits: read 0; writes to them are ignored.
- Address decode: if PADDR[APB_ADDR_WIDTH-1:4] != 0 and PSEL, then PSLVERR = 1, PRDATA = 0, and writes are ignored. PSLVERR = 0 whenever PSEL = 0.
- Pending next state: (pending & ~w1c) | edge | swset. Set beats clear when a hardware edge (or swset) and W1C hit the same bit in the same cycle.
- Mask: does not gate pending latching, only irq_o and the ID. Unmasking an already-pending bit asserts irq_o on the next edge.
- Output: irq_o <= |(pending & mask), registered.
- Latency: irq_i high sampled at edge E0 -> pending set after E0 -> irq_o = 1 after E1. W1C at edge E0 -> irq_o = 0 after E1 if nothing else is pending.
- ID: irq_id_o is combinational from registered pending & mask; lowest index wins.
- Reset mid-operation: all state clears immediately; no pending bit survives.

Optional Feature:
- Macro: APB_IRQ_CTRL_SYNC_EN.
- Defined: a 2-flop synchronizer (reset 0) per irq_i bit sits ahead of edge detect, so sources may come from clk32_i-domain logic. irq_i-to-pending latency grows by 2 cycles (irq_o after E3).
- Undefined: irq_i is used directly; sources must be HCLK-synchronous.

Decomposition:
- Package apb_irq_ctrl_pkg: register offset constants (MASK_OFS, PEND_OFS, PSET_OFS, ID_OFS), ID valid bit position, max source count 32.
- Sub-module irq_edge_detect: per-bit optional synchronizer plus edge-history flop, outputting the edge vector. Instantiated once with width IRQ_CNT.

Test Plan:
- Reset, then read all four registers -> MASK = 0, PENDING = 0, ID = 0x0000_0000, irq_o = 0, PREADY = 1.
- MASK = 0xF; pulse irq_i[1] for one cycle -> PENDING = 0x2, irq_o = 1 two edges later, ID = 0x8000_0001; write PENDING = 0x2 -> irq_o = 0 one edge later.
- MASK = 0x0; pulse irq_i[3] -> PENDING = 0x8, irq_o stays 0; write MASK = 0x8 -> irq_o = 1 next edge, ID = 0x8000_0003.
- irq_i[0] rising in the same cycle as a W1C write of 0x1 -> PENDING[0] stays 1. irq_i[2] held high for 10 cycles -> exactly one pending set.
- PENDING_SET write 0x5 with MASK = 0xF -> PENDING = 0x5, ID = 0x8000_0000; W1C 0x1 -> ID = 0x8000_0002.
- Access to PADDR = 0x010 -> PSLVERR = 1, PRDATA = 0, MASK unchanged. Assert HRESETn low with PENDING = 0xF -> all cleared asynchronously, irq_o = 0.
